// File: rtl/red_serial_sequencer.sv
// red_serial_sequencer
//   Walks the right-to-left iterative cell network one cell per clock through a
//   single shared external cell: the initial cell (bit 0), then N-1 typical cells,
//   then the final cell (bit N). The sequencer presents the operand bits and the
//   incoming state to the cell, and registers the cell's combinational output.
//
//   Optional feature macro: RED_SEQ_TRACE_EN
//     defined   : x_p carries the per-cell state trace (x_p[i] = output of cell i)
//     undefined : trace register is not built and x_p is tied to zero
//   Z, done and all timing are identical in both builds.
module red_serial_sequencer #(
    parameter int N = 4   // network order, N >= 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   a_p,
    input  logic [N:0]   b_p,
    output logic         busy,
    output logic         done,
    output logic         Z,
    output logic [N-1:0] x_p,
    output logic [1:0]   cell_sel,
    output logic         cell_a,
    output logic         cell_b,
    output logic         cell_x,
    input  logic         cell_px
);

    // idx addresses one of the N+1 operand bits, so clog2(N+1) bits suffice
    localparam int IW = (N + 1 > 1) ? $clog2(N + 1) : 1;

    localparam logic [1:0] SEL_INIT = 2'b00;
    localparam logic [1:0] SEL_TYP  = 2'b01;
    localparam logic [1:0] SEL_FIN  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_TYP,
        S_FIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [N:0]    a_q,     a_d;
    logic [N:0]    b_q,     b_d;
    logic          x_q,     x_d;
    logic          z_q,     z_d;

    logic accept;
    logic last_typ;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_typ = (idx_q == IW'(N - 1));

    // Next-state logic: a start is only honoured in IDLE; DONE always returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (N > 1) begin
                    state_d = S_TYP;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_TYP: begin
                if (last_typ) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand capture, bit index, running state and final result updates
    always_comb begin
        idx_d = idx_q;
        a_d   = a_q;
        b_d   = b_q;
        x_d   = x_q;
        z_d   = z_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // operands are frozen here; later a_p/b_p changes are ignored
                    a_d   = a_p;
                    b_d   = b_p;
                    idx_d = '0;
                    z_d   = 1'b0;
                end
            end
            S_INIT: begin
                x_d   = cell_px;
                idx_d = IW'(1);
            end
            S_TYP: begin
                x_d = cell_px;
                // idx stops at N-1; FIN uses the fixed top bit, so no wrap is needed
                if (!last_typ) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_FIN: begin
                z_d = cell_px;
            end
            default: begin
            end
        endcase
    end

    // Cell interface and handshake outputs, decoded straight from state and registers
    always_comb begin
        cell_sel = SEL_NONE;
        cell_a   = 1'b0;
        cell_b   = 1'b0;
        cell_x   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_INIT: begin
                cell_sel = SEL_INIT;
                cell_a   = a_q[0];
                cell_b   = b_q[0];
                cell_x   = 1'b0;
                busy     = 1'b1;
            end
            S_TYP: begin
                cell_sel = SEL_TYP;
                cell_a   = a_q[idx_q];
                cell_b   = b_q[idx_q];
                cell_x   = x_q;
                busy     = 1'b1;
            end
            S_FIN: begin
                cell_sel = SEL_FIN;
                cell_a   = a_q[N];
                cell_b   = b_q[N];
                cell_x   = x_q;
                busy     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            z_q     <= z_d;
        end
    end

    assign Z = z_q;

`ifdef RED_SEQ_TRACE_EN
    logic [N-1:0] xp_q, xp_d;

    // Trace register: cleared on accept, records each state-chain cell output
    always_comb begin
        xp_d = xp_q;
        if (accept) begin
            xp_d = '0;
        end else if (state_q == S_INIT) begin
            xp_d[0] = cell_px;
        end else if (state_q == S_TYP) begin
            for (int i = 0; i < N; i++) begin
                if (idx_q == IW'(i)) begin
                    xp_d[i] = cell_px;
                end
            end
        end
    end

    // Trace flop bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xp_q <= '0;
        end else begin
            xp_q <= xp_d;
        end
    end

    assign x_p = xp_q;
`else
    assign x_p = '0;
`endif

endmodule
